// File: rtl/cpu_pkg.sv
// Shared CPU datapath types for the multiply/divide engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } md_state_t;

    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = 6;

endpackage

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) engine.
// Latency: multiply 33 edges after sampling, divide 34, divide-by-zero 1.
// Backpressure: 4-phase level handshake; done held until the request drops.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = MD_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_ctrl,
    input  logic             div_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_done,
    output logic             div_done,
    output logic             div_zero,
    output logic             busy
);

    localparam logic [MD_CNT_W-1:0] LAST = MD_CNT_W'(ITERS);

    md_state_t           state_q, state_d;
    logic [WIDTH:0]      acc_q, acc_d;          // extra bit keeps the sign of add/sub results
    logic [WIDTH-1:0]    q_q, q_d;              // multiplier / dividend-quotient shift register
    logic [WIDTH-1:0]    m_q, m_d;              // multiplicand / divisor magnitude
    logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic                q1_q, q1_d;            // Booth q-1 bit
    logic                sa_q, sa_d, sb_q, sb_d;
    logic                is_mult_q, is_mult_d;
    logic                mult_done_q, mult_done_d;
    logic                div_done_q, div_done_d;
    logic                div_zero_q, div_zero_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]      booth_m, booth_sum, div_sh, div_trial;
    logic [WIDTH-1:0]    a_abs, b_abs, quo_fix, rem_fix;

    // Per-step arithmetic shared by the next-state logic
    always_comb begin
        a_abs   = a[WIDTH-1] ? -a : a;
        b_abs   = b[WIDTH-1] ? -b : b;
        booth_m = {m_q[WIDTH-1], m_q};
        case ({q_q[0], q1_q})
            2'b01:   booth_sum = acc_q + booth_m;
            2'b10:   booth_sum = acc_q - booth_m;
            default: booth_sum = acc_q;
        endcase
        div_sh    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, m_q};
        quo_fix   = (sa_q ^ sb_q) ? -q_q : q_q;
        rem_fix   = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    // Next state and datapath next values
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        q_d         = q_q;
        q1_d        = q1_q;
        m_d         = m_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        is_mult_d   = is_mult_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mult_done_d = mult_done_q;
        div_done_d  = div_done_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                q1_d  = 1'b0;
                if (mult_ctrl) begin
                    state_d   = MULT;
                    q_d       = b;
                    m_d       = a;
                    is_mult_d = 1'b1;
                end else if (div_ctrl) begin
                    state_d   = DIV;
                    q_d       = a_abs;
                    m_d       = b_abs;
                    sa_d      = a[WIDTH-1];
                    sb_d      = b[WIDTH-1];
                    is_mult_d = 1'b0;
                end
            end
            MULT: begin
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    hi_d        = acc_q[WIDTH-1:0];
                    lo_d        = q_q;
                    mult_done_d = 1'b1;
                end else begin
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                    q1_d  = q_q[0];
                    cnt_d = cnt_q + MD_CNT_W'(1);
                end
            end
            DIV: begin
                if (m_q == '0) begin
                    // Divisor of zero: report it and leave HI/LO untouched
                    state_d    = DONE;
                    div_done_d = 1'b1;
                    div_zero_d = 1'b1;
                end else if (cnt_q == LAST) begin
                    state_d = FIX;
                    q_d     = quo_fix;
                    acc_d   = {1'b0, rem_fix};
                end else begin
                    if (div_trial[WIDTH]) begin
                        acc_d = div_sh;
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = div_trial;
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + MD_CNT_W'(1);
                end
            end
            FIX: begin
                state_d    = DONE;
                hi_d       = acc_q[WIDTH-1:0];
                lo_d       = q_q;
                div_done_d = 1'b1;
            end
            DONE: begin
                if (is_mult_q ? !mult_ctrl : !div_ctrl) begin
                    state_d     = IDLE;
                    mult_done_d = 1'b0;
                    div_done_d  = 1'b0;
                    div_zero_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            q_q         <= '0;
            q1_q        <= 1'b0;
            m_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            is_mult_q   <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mult_done_q <= 1'b0;
            div_done_q  <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            q_q         <= q_d;
            q1_q        <= q1_d;
            m_q         <= m_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            is_mult_q   <= is_mult_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mult_done_q <= mult_done_d;
            div_done_q  <= div_done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mult_done = mult_done_q;
    assign div_done  = div_done_q;
    assign div_zero  = div_zero_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized operations.
// Expected outputs come from 64-bit signed arithmetic and fixed handshake latencies.
// Outputs are compared on every falling edge against the model's expected values.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_done;
    logic        div_done;
    logic        div_zero;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi, exp_lo;
    logic        exp_mdone, exp_ddone, exp_dz, exp_busy;
    bit          chk_en = 0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mult_ctrl (mult_ctrl),
        .div_ctrl  (div_ctrl),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .mult_done (mult_done),
        .div_done  (div_done),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Architectural result of one operation
    function automatic void model(input bit is_mult, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [31:0] old_hi, input logic [31:0] old_lo,
                                  output logic [31:0] h, output logic [31:0] l, output bit dz);
        longint pa, pb, p, qq, rr;
        pa = longint'($signed(av));
        pb = longint'($signed(bv));
        dz = 0;
        h  = old_hi;
        l  = old_lo;
        if (is_mult) begin
            p = pa * pb;
            h = p[63:32];
            l = p[31:0];
        end else if (bv == 32'd0) begin
            dz = 1;
        end else begin
            qq = pa / pb;
            rr = pa % pb;
            h  = rr[31:0];
            l  = qq[31:0];
        end
    endfunction

    // Continuous compare against the model's expectations
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("hi",        hi,        exp_hi);
                chk("lo",        lo,        exp_lo);
                chk("mult_done", {31'd0, mult_done}, {31'd0, exp_mdone});
                chk("div_done",  {31'd0, div_done},  {31'd0, exp_ddone});
                chk("div_zero",  {31'd0, div_zero},  {31'd0, exp_dz});
                chk("busy",      {31'd0, busy},      {31'd0, exp_busy});
            end
        end
    end

    // One complete operation; early=1 drops the request while the engine is still working
    task automatic do_op(input bit is_mult, input bit both, input logic [31:0] av, input logic [31:0] bv,
                         input int hold, input bit early);
        logic [31:0] h, l;
        bit dz;
        int lat, drop_at;
        model(is_mult, av, bv, exp_hi, exp_lo, h, l, dz);
        lat     = is_mult ? 33 : (bv == 32'd0 ? 1 : 34);
        drop_at = early ? int'($urandom_range(1, lat)) : 0;
        @(negedge clk);
        mult_ctrl = is_mult;
        div_ctrl  = !is_mult || both;
        a = av;
        b = bv;
        @(posedge clk); #1;
        exp_busy = 1;
        for (int e = 1; e <= lat; e++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            if (e == drop_at) begin
                mult_ctrl = 0;
                div_ctrl  = 0;
            end
            @(posedge clk); #1;
        end
        exp_hi    = h;
        exp_lo    = l;
        exp_mdone = is_mult;
        exp_ddone = !is_mult;
        exp_dz    = dz;
        chk("done_at_latency", {31'd0, (is_mult ? mult_done : div_done)}, 32'd1);
        if (both) chk("div_done_ignored", {31'd0, div_done}, 32'd0);
        if (drop_at == 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            mult_ctrl = 0;
            div_ctrl  = 0;
        end
        @(posedge clk); #1;
        exp_mdone = 0;
        exp_ddone = 0;
        exp_dz    = 0;
        exp_busy  = 0;
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] mh, ml;
        bit mdz;
        bit rm;
        logic [31:0] av, bv;
        int sel;

        reset = 0; mult_ctrl = 0; div_ctrl = 0; a = 0; b = 0;
        exp_hi = 0; exp_lo = 0; exp_mdone = 0; exp_ddone = 0; exp_dz = 0; exp_busy = 0;

        // Model pinned to hand-computed results
        model(1, 32'd7, 32'hFFFFFFFD, 0, 0, mh, ml, mdz);
        chk("model_mul_hi", mh, 32'hFFFFFFFF);
        chk("model_mul_lo", ml, 32'hFFFFFFEB);
        model(0, 32'hFFFFFFF9, 32'd2, 0, 0, mh, ml, mdz);
        chk("model_div_lo", ml, 32'hFFFFFFFD);
        chk("model_div_hi", mh, 32'hFFFFFFFF);
        model(0, 32'h80000000, 32'hFFFFFFFF, 0, 0, mh, ml, mdz);
        chk("model_ovf_lo", ml, 32'h80000000);
        chk("model_ovf_hi", mh, 32'h00000000);

        #1;
        chk("reset_hi",   hi, 32'd0);
        chk("reset_lo",   lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {30'd0, mult_done, div_done}, 32'd0);
        chk_en = 1;
        repeat (2) @(negedge clk);
        reset = 1;

        // Case 1 and 2: multiplies
        do_op(1, 0, 32'd7, 32'hFFFFFFFD, 2, 0);
        chk("t1_hi", hi, 32'hFFFFFFFF);
        chk("t1_lo", lo, 32'hFFFFFFEB);
        do_op(1, 0, 32'h80000000, 32'h80000000, 0, 0);
        chk("t2_hi", hi, 32'h40000000);
        chk("t2_lo", lo, 32'h00000000);

        // Case 3: signed divide
        do_op(0, 0, 32'hFFFFFFF9, 32'd2, 1, 0);
        chk("t3_lo", lo, 32'hFFFFFFFD);
        chk("t3_hi", hi, 32'hFFFFFFFF);

        // Case 4: establish hi/lo=0x11/0x22, then divide by zero keeps them
        do_op(0, 0, 32'h451, 32'h20, 0, 0);
        chk("t4_prior_hi", hi, 32'h11);
        chk("t4_prior_lo", lo, 32'h22);
        do_op(0, 0, 32'd100, 32'd0, 2, 0);
        chk("t4_hi_kept", hi, 32'h11);
        chk("t4_lo_kept", lo, 32'h22);

        // Case 5: overflow divide, then both requests high
        do_op(0, 0, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("t5_lo", lo, 32'h80000000);
        chk("t5_hi", hi, 32'h00000000);
        do_op(1, 1, 32'h12345678, 32'hFEDCBA98, 1, 0);

        // Case 6: asynchronous reset in the middle of a multiply
        @(negedge clk);
        mult_ctrl = 1; a = 32'h0BADF00D; b = 32'h12345;
        @(posedge clk); #1;
        exp_busy = 1;
        repeat (10) @(posedge clk);
        #3;
        reset = 0;
        exp_hi = 0; exp_lo = 0; exp_mdone = 0; exp_ddone = 0; exp_dz = 0; exp_busy = 0;
        #1;
        chk("t6_rst_hi",   hi, 32'd0);
        chk("t6_rst_lo",   lo, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_done", {31'd0, mult_done}, 32'd0);
        @(negedge clk);
        mult_ctrl = 0;
        @(negedge clk);
        reset = 1;
        do_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        chk("t6_after_hi", hi, 32'd0);
        chk("t6_after_lo", lo, 32'd1);

        // Early request drop still completes
        do_op(0, 0, 32'd1000, 32'hFFFFFFF9, 0, 1);
        do_op(1, 0, 32'hFFFF0000, 32'h00010001, 0, 1);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            rm  = 1'($urandom_range(0, 1));
            av  = $urandom;
            bv  = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      bv = 32'd0;
            else if (sel == 1) bv = 32'hFFFFFFFF;
            else if (sel == 2) av = 32'h80000000;
            else if (sel == 3) bv = $urandom_range(1, 15);
            else if (sel == 4) bv = -$urandom_range(1, 15);
            do_op(rm, 0, av, bv, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
